// File: rtl/audio_pkg.sv
// audio_pkg
// Shared definitions for the audio_seq tone sequencer:
//   audio_state_t - playback FSM states (IDLE, PLAY, PAUSE)
//   AUDIO_FREQ_W  - default width of beat rate and tone frequencies (Hz)
//   acc_width()   - phase accumulator width for a given modulus; wide
//                   enough to hold any value below twice the modulus
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2
    } audio_state_t;

    localparam int AUDIO_FREQ_W = 28;

    function automatic int acc_width(input longint modulus);
        return $clog2(longint'(2) * modulus);
    endfunction

endpackage

// File: rtl/audio_seq_tone_nco.sv
// tone_nco
// Phase accumulator with modulus MOD. Every enabled cycle the accumulator
// advances by freq_i; when the sum reaches MOD it wraps (MOD is subtracted),
// wrap_o pulses for that cycle and sq_o toggles on the next edge.
// While disabled the accumulator holds its phase and sq_o is forced low.
// Used both as a square-wave voice (MOD = CLK_HZ/2, output sq_o) and as the
// beat tick generator (MOD = CLK_HZ, output wrap_o).
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   en_i        - advance the accumulator this cycle
//   clr_i       - clear accumulator and square wave (wins over en_i)
//   freq_i      - phase increment per cycle
//   wrap_o      - combinational wrap pulse for the current cycle
//   sq_o        - registered square wave
module tone_nco
    import audio_pkg::*;
#(
    parameter int MOD    = 500,
    parameter int FREQ_W = AUDIO_FREQ_W,
    parameter int ACC_W  = acc_width(longint'(MOD))
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic [FREQ_W-1:0] freq_i,
    output logic              wrap_o,
    output logic              sq_o
);

    // One extra bit so the sum never overflows before the compare.
    localparam int SUM_W = ((ACC_W > FREQ_W) ? ACC_W : FREQ_W) + 1;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sq_q, sq_d;
    logic [SUM_W-1:0] sum;

    assign sum    = SUM_W'(acc_q) + SUM_W'(freq_i);
    assign wrap_o = en_i && (sum >= SUM_W'(MOD));
    assign sq_o   = sq_q;

    // Muting holds the phase, so a voice resumes without a phase jump.
    always_comb begin
        acc_d = acc_q;
        sq_d  = sq_q;
        if (clr_i) begin
            acc_d = '0;
            sq_d  = 1'b0;
        end else if (!en_i) begin
            sq_d = 1'b0;
        end else if (wrap_o) begin
            acc_d = ACC_W'(sum - SUM_W'(MOD));
            sq_d  = ~sq_q;
        end else begin
            acc_d = ACC_W'(sum);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            sq_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sq_q  <= sq_d;
        end
    end

endmodule

// File: rtl/audio_seq.sv
// audio_seq
// Multi-channel tone sequencer. A beat NCO produces ticks at beat_freq while
// playing; each tick steps ibeat through a track of track_len beats. The
// external score returns one frequency per channel for ibeat; each channel
// is synthesised as a square wave and the channels are mixed onto pmod_1 by
// a first-order sigma-delta modulator.
// Optional feature macro: AUDIO_LOOP_EN adds the loop input; without it the
// end of the track always returns to IDLE with a done pulse.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   beat_freq   - beats per second (0 freezes beat advance)
//   track_len   - beats in the track (0 = empty, start ignored)
//   start/stop  - single-cycle play / abort requests (stop wins)
//   pause       - level, holds playback and mutes all channels
//   loop        - level, wrap to beat 0 at end of track (AUDIO_LOOP_EN)
//   ibeat       - registered beat index, drives the score lookup
//   tone        - per-channel frequency, channel k at [k*FREQ_W +: FREQ_W]
//   busy        - high in PLAY or PAUSE
//   done        - one-cycle pulse when a non-looping track ends
//   pmod_1      - sigma-delta mixed audio
//   pmod_2      - amplifier gain select, tied high
module audio_seq
    import audio_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int CHANNELS = 2,
    parameter int BEAT_W   = 8,
    parameter int FREQ_W   = AUDIO_FREQ_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [FREQ_W-1:0]          beat_freq,
    input  logic [BEAT_W-1:0]          track_len,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       pause,
`ifdef AUDIO_LOOP_EN
    input  logic                       loop,
`endif
    output logic [BEAT_W-1:0]          ibeat,
    input  logic [CHANNELS*FREQ_W-1:0] tone,
    output logic                       busy,
    output logic                       done,
    output logic                       pmod_1,
    output logic                       pmod_2
);

    localparam int N_W = $clog2(CHANNELS + 1);
    localparam int M_W = $clog2(2 * CHANNELS + 1);

    audio_state_t               state_q, state_d;
    logic [BEAT_W-1:0]          ibeat_q, ibeat_d;
    logic                       done_q, done_d;
    logic [CHANNELS*FREQ_W-1:0] tone_q;
    logic [CHANNELS-1:0]        sq;
    logic [CHANNELS-1:0]        tone_wrap_unused;
    logic [M_W-1:0]             macc_q, macc_d;
    logic                       pmod_q, pmod_d;
    logic [N_W-1:0]             n;
    logic [M_W-1:0]             macc_sum;
    logic                       tick;
    logic                       beat_en;
    logic                       beat_clr;
    logic                       beat_sq_unused;
    logic                       loop_en;

`ifdef AUDIO_LOOP_EN
    assign loop_en = loop;
`else
    assign loop_en = 1'b0;
`endif

    // Pause and stop both outrank the tick, so the beat phase only moves in
    // an unpaused PLAY cycle. Holding the accumulator clear whenever the
    // next state is IDLE means every fresh start begins at phase 0.
    assign beat_en  = (state_q == PLAY) && !pause && !stop;
    assign beat_clr = (state_d == IDLE);

    tone_nco #(
        .MOD    (CLK_HZ),
        .FREQ_W (FREQ_W),
        .ACC_W  (acc_width(longint'(CLK_HZ)))
    ) u_beat (
        .clk    (clk),
        .reset  (reset),
        .en_i   (beat_en),
        .clr_i  (beat_clr),
        .freq_i (beat_freq),
        .wrap_o (tick),
        .sq_o   (beat_sq_unused)
    );

    always_comb begin
        state_d = state_q;
        ibeat_d = ibeat_q;
        done_d  = 1'b0;
        if (stop) begin
            state_d = IDLE;
            ibeat_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && (track_len != '0)) begin
                        state_d = PLAY;
                        ibeat_d = '0;
                    end
                end
                PLAY: begin
                    if (pause) begin
                        state_d = PAUSE;
                    end else if (tick) begin
                        if (ibeat_q == track_len - 1'b1) begin
                            ibeat_d = '0;
                            if (!loop_en) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            ibeat_d = ibeat_q + 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (!pause) begin
                        state_d = PLAY;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Voices run at half the clock modulus because each wrap is only half
    // a period of the square wave.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_voice
        tone_nco #(
            .MOD    (CLK_HZ / 2),
            .FREQ_W (FREQ_W),
            .ACC_W  (acc_width(longint'(CLK_HZ / 2)))
        ) u_voice (
            .clk    (clk),
            .reset  (reset),
            .en_i   ((state_q == PLAY) && (tone_q[k*FREQ_W +: FREQ_W] != '0)),
            .clr_i  (1'b0),
            .freq_i (tone_q[k*FREQ_W +: FREQ_W]),
            .wrap_o (tone_wrap_unused[k]),
            .sq_o   (sq[k])
        );
    end

    // First-order sigma-delta: the residue stays below CHANNELS, so the
    // density of pmod_1 tracks the fraction of voices currently high.
    always_comb begin
        n = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            n = n + N_W'(sq[k]);
        end
        macc_sum = macc_q + M_W'(n);
        if (macc_sum >= M_W'(CHANNELS)) begin
            pmod_d = 1'b1;
            macc_d = macc_sum - M_W'(CHANNELS);
        end else begin
            pmod_d = 1'b0;
            macc_d = macc_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ibeat_q <= '0;
            done_q  <= 1'b0;
            tone_q  <= '0;
            macc_q  <= '0;
            pmod_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ibeat_q <= ibeat_d;
            done_q  <= done_d;
            tone_q  <= tone;
            macc_q  <= macc_d;
            pmod_q  <= pmod_d;
        end
    end

    assign ibeat  = ibeat_q;
    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign pmod_1 = pmod_q;
    assign pmod_2 = 1'b1;

endmodule

// File: tb/tb_audio_seq.sv
// tb_audio_seq
// Directed bench for audio_seq at CLK_HZ = 1000 and two channels. Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_audio_seq;

    localparam int CLK_HZ   = 1000;
    localparam int CHANNELS = 2;
    localparam int BEAT_W   = 8;
    localparam int FREQ_W   = 28;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [FREQ_W-1:0]          beat_freq;
    logic [BEAT_W-1:0]          track_len;
    logic                       start;
    logic                       stop;
    logic                       pause;
`ifdef AUDIO_LOOP_EN
    logic                       loop;
`endif
    logic [BEAT_W-1:0]          ibeat;
    logic [CHANNELS*FREQ_W-1:0] tone;
    logic                       busy;
    logic                       done;
    logic                       pmod_1;
    logic                       pmod_2;

    int checks = 0;
    int errors = 0;
    int donePulses = 0;

    audio_seq #(
        .CLK_HZ   (CLK_HZ),
        .CHANNELS (CHANNELS),
        .BEAT_W   (BEAT_W),
        .FREQ_W   (FREQ_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .beat_freq (beat_freq),
        .track_len (track_len),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
`ifdef AUDIO_LOOP_EN
        .loop      (loop),
`endif
        .ibeat     (ibeat),
        .tone      (tone),
        .busy      (busy),
        .done      (done),
        .pmod_1    (pmod_1),
        .pmod_2    (pmod_2)
    );

    always #5 clk = ~clk;

    // Running count of done pulses, read as differences by the main sequence.
    always @(negedge clk) begin
        if (done === 1'b1) donePulses++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Pulse start/stop for one cycle; returns on the following falling edge.
    task automatic applyStimulus(input logic startV, input logic stopV);
        start = startV;
        stop  = stopV;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic waitCycles(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        int d0;
        int sqHigh;
        int sqEdges;
        int sq1High;
        int pmodHigh;
        logic prevSq;

        reset     = 1'b1;
        beat_freq = '0;
        track_len = '0;
        start     = 1'b0;
        stop      = 1'b0;
        pause     = 1'b0;
`ifdef AUDIO_LOOP_EN
        loop      = 1'b0;
`endif
        tone      = {28'd0, 28'd100};

        waitCycles(3);
        checkOutput("resetPmod2", 32'(pmod_2), 32'd1);
        checkOutput("resetPmod1", 32'(pmod_1), 32'd0);
        checkOutput("resetBusy",  32'(busy),   32'd0);
        checkOutput("resetDone",  32'(done),   32'd0);
        checkOutput("resetIbeat", 32'(ibeat),  32'd0);
        reset = 1'b0;
        waitCycles(1);

        $display("[TB] empty track and start+stop from IDLE");
        applyStimulus(1'b1, 1'b0);
        checkOutput("emptyTrackBusy", 32'(busy), 32'd0);
        track_len = 8'd3;
        beat_freq = 28'd100;
        applyStimulus(1'b1, 1'b1);
        checkOutput("startStopBusy",  32'(busy),  32'd0);
        checkOutput("startStopIbeat", 32'(ibeat), 32'd0);
        waitCycles(2);

        $display("[TB] three-beat track without loop");
        d0 = donePulses;
        applyStimulus(1'b1, 1'b0);
        checkOutput("beatStartBusy", 32'(busy),  32'd1);
        checkOutput("beatStartIdx",  32'(ibeat), 32'd0);
        waitCycles(9);
        checkOutput("beat0Last",  32'(ibeat), 32'd0);
        waitCycles(1);
        checkOutput("beat1First", 32'(ibeat), 32'd1);
        waitCycles(9);
        checkOutput("beat1Last",  32'(ibeat), 32'd1);
        waitCycles(1);
        checkOutput("beat2First", 32'(ibeat), 32'd2);
        waitCycles(9);
        checkOutput("beat2Last",  32'(ibeat), 32'd2);
        checkOutput("beat2Busy",  32'(busy),  32'd1);
        checkOutput("beat2Done",  32'(done),  32'd0);
        waitCycles(1);
        checkOutput("endBusy",  32'(busy),  32'd0);
        checkOutput("endDone",  32'(done),  32'd1);
        checkOutput("endIbeat", 32'(ibeat), 32'd0);
        waitCycles(2);
        checkOutput("endDoneLow",   32'(done),        32'd0);
        checkOutput("endDoneCount", donePulses - d0,  32'd1);

`ifdef AUDIO_LOOP_EN
        $display("[TB] three-beat track with loop");
        loop = 1'b1;
        d0 = donePulses;
        applyStimulus(1'b1, 1'b0);
        waitCycles(29);
        checkOutput("loopBeat2", 32'(ibeat), 32'd2);
        waitCycles(1);
        checkOutput("loopWrapIdx",  32'(ibeat), 32'd0);
        checkOutput("loopWrapBusy", 32'(busy),  32'd1);
        waitCycles(10);
        checkOutput("loopNextBeat",  32'(ibeat),       32'd1);
        checkOutput("loopDoneCount", donePulses - d0,  32'd0);
        applyStimulus(1'b0, 1'b1);
        loop = 1'b0;
        waitCycles(2);
`endif

        $display("[TB] tones {100,0} with frozen beat");
        beat_freq = 28'd0;
        track_len = 8'd5;
        tone      = {28'd0, 28'd100};
        applyStimulus(1'b1, 1'b0);
        waitCycles(19);
        prevSq   = dut.sq[0];
        sqHigh   = 0;
        sqEdges  = 0;
        sq1High  = 0;
        pmodHigh = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dut.sq[0] === 1'b1) sqHigh++;
            if (dut.sq[0] !== prevSq) sqEdges++;
            if (dut.sq[1] === 1'b1) sq1High++;
            if (pmod_1 === 1'b1) pmodHigh++;
            prevSq = dut.sq[0];
        end
        checkOutput("toneSq0High",  sqHigh,   32'd20);
        checkOutput("toneSq0Edges", sqEdges,  32'd8);
        checkOutput("toneSq1High",  sq1High,  32'd0);
        checkOutput("tonePmodHigh", pmodHigh, 32'd10);
        checkOutput("toneFrozenIdx", 32'(ibeat), 32'd0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("toneStopBusy", 32'(busy), 32'd0);
        waitCycles(2);

        $display("[TB] pause held for 50 cycles mid-beat");
        beat_freq = 28'd100;
        track_len = 8'd3;
        applyStimulus(1'b1, 1'b0);
        waitCycles(3);
        checkOutput("prePauseIdx", 32'(ibeat), 32'd0);
        pause    = 1'b1;
        pmodHigh = 0;
        for (int i = 5; i <= 54; i++) begin
            @(negedge clk);
            if (i >= 10 && pmod_1 === 1'b1) pmodHigh++;
        end
        checkOutput("pausePmodHigh", pmodHigh,    32'd0);
        checkOutput("pauseIdx",      32'(ibeat), 32'd0);
        checkOutput("pauseBusy",     32'(busy),  32'd1);
        pause = 1'b0;
        waitCycles(7);
        checkOutput("resumeBeforeTick", 32'(ibeat), 32'd0);
        waitCycles(1);
        checkOutput("resumeAfterTick",  32'(ibeat), 32'd1);

        $display("[TB] stop during PLAY");
        d0 = donePulses;
        applyStimulus(1'b0, 1'b1);
        checkOutput("stopBusy",  32'(busy),  32'd0);
        checkOutput("stopIbeat", 32'(ibeat), 32'd0);
        checkOutput("stopDone",  32'(done),  32'd0);
        waitCycles(2);
        checkOutput("stopDoneCount", donePulses - d0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_seq.md
# audio_seq

Multi-channel tone sequencer: successor to the single-voice beat player in `src/music`.
- Generates beat ticks from a programmable beat rate and steps a beat index through a track of programmable length.
- Samples one tone frequency per channel from an external combinational score lookup and synthesises each as a square wave.
- Mixes the channels onto the 1-bit PMOD audio pin with a first-order sigma-delta modulator.
- Adds start/stop/pause control, end-of-track signalling and optional looping.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000: system clock frequency; modulus for all phase accumulators.
- `CHANNELS`, 2: number of simultaneous voices (1..8).
- `BEAT_W`, 8: beat index width.
- `FREQ_W`, 28: width of the beat rate and of each tone frequency (Hz).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: reset. One clock; reset is synchronous and active-high.
- `beat_freq` in `FREQ_W`: beats per second; 0 freezes beat advance.
- `track_len` in `BEAT_W`: number of beats in the track; 0 means empty track.
- `start` in 1: single-cycle request to play from beat 0.
- `stop` in 1: single-cycle request to abort playback.
- `pause` in 1: level; holds playback while high.
- `loop` in 1: level; wrap to beat 0 at end of track (present only with `AUDIO_LOOP_EN`).
- `ibeat` out `BEAT_W`: current beat index, registered; drives the external score lookup.
- `tone` in `CHANNELS*FREQ_W`: per-channel frequency for `ibeat`; channel k is bits `[k*FREQ_W +: FREQ_W]`; 0 = rest.
- `busy` out 1: high in PLAY or PAUSE.
- `done` out 1: one-cycle pulse when a non-looping track ends.
- `pmod_1` out 1: sigma-delta mixed audio.
- `pmod_2` out 1: amplifier gain select; constant 1 (no 6 dB gain).

## Operation
FSM states: IDLE, PLAY, PAUSE.

Reset values:
- State IDLE; `ibeat`=0, `busy`=0, `done`=0, `pmod_1`=0, `pmod_2`=1.
- All accumulators, channel square waves and the registered tone vector are 0.

Beat tick:
- In PLAY only: `bacc += beat_freq`.
- If the sum ≥ `CLK_HZ`, subtract `CLK_HZ` and assert `tick` for one cycle.
- `bacc` width is clog2(2*`CLK_HZ`); `beat_freq` must be < `CLK_HZ`.

State transitions:
- IDLE + `start`, with `track_len`≠0: go to PLAY with `ibeat`=0 and `bacc`=0. `start` with `track_len`=0 is ignored.
- PLAY + `tick`:
  - If `ibeat`==`track_len`-1: with `loop`, set `ibeat`=0 and stay in PLAY; otherwise go to IDLE, set `ibeat`=0 and pulse `done`.
  - Else `ibeat += 1`.
- PLAY + `pause`: go to PAUSE. `bacc` is frozen, the tick is suppressed and all channels are muted.
- PAUSE + `!pause`: return to PLAY. `bacc` resumes from its frozen value.
- Any state + `stop`: go to IDLE with `ibeat`=0 and `bacc`=0; `done` is not pulsed.

Priority:
- `stop` > `start`.
- `stop` > tick.
- `pause` > tick in the same cycle.
- `start` while busy is ignored.

Tone path:
- `tone` is registered every cycle into `tone_q`.
- Channel k: `tacc_k += tone_q[k]`. If the sum ≥ `CLK_HZ/2`, subtract `CLK_HZ/2` and toggle `sq_k`. This yields a square wave at exactly `tone_q[k]` Hz.
- Rest (0) or state ≠ PLAY: `sq_k` is forced to 0; `tacc_k` holds.
- A frequency change does not reset `tacc_k`, so phase is continuous.

Mixer:
- `n` = popcount of `sq`.
- `macc += n`. If `macc` ≥ `CHANNELS`, set `pmod_1`=1 and `macc -= CHANNELS`; else `pmod_1`=0.
- The density of `pmod_1` therefore equals `n/CHANNELS`.

## Timing
- `ibeat` changes on the clock edge after the `tick` cycle.
- `tone_q` is valid one cycle after `ibeat` changes.
- `sq_k` responds one further cycle later; `pmod_1` one cycle after that.
- Start-to-first-audio latency is 3 cycles after the PLAY entry edge.
- `done` is asserted in the same cycle that `busy` falls.
- `busy` rises on the edge that samples `start`.

## Configuration
`AUDIO_LOOP_EN`:
- Defined: the `loop` port exists and looping behaves as described under Operation.
- Undefined: the `loop` port is absent and the end of track always returns to IDLE with a `done` pulse.

## Structure
- `audio_pkg` holds:
  - the state enum `audio_state_t` (IDLE, PLAY, PAUSE);
  - `AUDIO_FREQ_W`;
  - a `clog2`-based accumulator width function.
- One sub-module, `tone_nco`: the per-channel accumulator, toggle and mute. It is instantiated `CHANNELS` times in a generate loop and also reused for the beat tick with modulus `CLK_HZ` and output taken as the pulse rather than the toggle.

## Test plan
Bench uses `CLK_HZ`=1000 and `CHANNELS`=2.
- Reset: `pmod_2`=1, every other output 0, state IDLE.
- `beat_freq`=100, `track_len`=3, start, `loop`=0: `ibeat` runs 0,1,2 with one advance every 10 cycles; then a `done` pulse, `busy` falls and `ibeat`=0.
- `loop`=1, same setup: after beat 2, `ibeat` wraps to 0, `busy` stays high and no `done` pulse occurs.
- Tones {100,0}: `sq_0` has a 10-cycle period; `pmod_1` density is 25% (1/4 of cycles over 40 cycles); `sq_1` stays 0.
- `pause` held for 50 cycles mid-beat: `ibeat` is frozen and `pmod_1`=0. After release, the next tick arrives after the remaining cycles of the beat.
- `start`+`stop` in the same cycle from IDLE: stays IDLE. `stop` during PLAY: IDLE next cycle, `ibeat`=0, no `done` pulse.
